// File: rtl/fizzbuzz_sequencer_pkg.sv
// Shared definitions for the fizzbuzz sequencer: FSM encoding and divisors.
package fizzbuzz_sequencer_pkg;

   localparam int FIZZ_MOD = 3;
   localparam int BUZZ_MOD = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fizzbuzz_residue.sv
// Running residue counter n mod MOD. Loads an initial residue, then tracks n+1
// with a cheap increment-and-wrap instead of a divider. wrap_clr resets to 0
// when n itself wraps to 0, since 2**BITS is not a multiple of MOD.
module fizzbuzz_residue #(
   parameter int MOD = 3,
   parameter int W   = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         step,
   input  logic         wrap_clr,
   output logic [W-1:0] r
);

   // load beats wrap_clr beats step; wrap_clr and step arrive together on a wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r <= '0;
      else if (load)
         r <= load_val;
      else if (wrap_clr)
         r <= '0;
      else if (step)
         r <= (r == W'(MOD - 1)) ? '0 : r + W'(1);
   end

endmodule

// File: rtl/fizzbuzz_sequencer.sv
// Streams (n, n%3==0, n%5==0) for every n in [first, last] (wrapping modulo
// 2**BITS) over a valid/ready interface, one result per handshake.
module fizzbuzz_sequencer
   import fizzbuzz_sequencer_pkg::*;
#(
   parameter int BITS = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [BITS-1:0] first,
   input  logic [BITS-1:0] last,
   input  logic            abort,
   output logic            busy,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] n_out,
   output logic            fizz,
   output logic            buzz,
   output logic            done
);

   localparam int W3 = $clog2(FIZZ_MOD);
   localparam int W5 = $clog2(BUZZ_MOD);

   state_t          state;
   logic [BITS-1:0] last_q;
   logic [W3-1:0]   r3, m3;
   logic [W5-1:0]   r5, m5;
   logic            accept, hs, step, fin, wrap;

   // constant-divisor residues of the incoming first value, used only on accept
   assign m3 = W3'(first % BITS'(FIZZ_MOD));
   assign m5 = W5'(first % BITS'(BUZZ_MOD));

   // abort wins over a same-cycle handshake
   assign accept = (state == ST_IDLE) && start;
   assign hs     = (state == ST_RUN) && out_valid && out_ready && !abort;
   assign step   = hs && (n_out != last_q);
   assign fin    = hs && (n_out == last_q);
   assign wrap   = step && (n_out == {BITS{1'b1}});

   assign busy = (state != ST_IDLE);

   fizzbuzz_residue #(.MOD(FIZZ_MOD), .W(W3)) u_res3 (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .load_val (m3),
      .step     (step),
      .wrap_clr (wrap),
      .r        (r3)
   );

   fizzbuzz_residue #(.MOD(BUZZ_MOD), .W(W5)) u_res5 (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .load_val (m5),
      .step     (step),
      .wrap_clr (wrap),
      .r        (r5)
   );

   // Sequencer FSM with registered outputs. fizz/buzz are registered alongside
   // n_out from the residue the counters will hold next, so they always equal
   // (r3==0)/(r5==0) while a result is presented.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         n_out     <= '0;
         fizz      <= 1'b0;
         buzz      <= 1'b0;
         done      <= 1'b0;
         last_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= ST_RUN;
                  out_valid <= 1'b1;
                  n_out     <= first;
                  last_q    <= last;
                  fizz      <= (m3 == '0);
                  buzz      <= (m5 == '0);
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end else if (fin) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b0;
                  done      <= 1'b1;
               end else if (step) begin
                  n_out <= n_out + BITS'(1);
                  fizz  <= wrap || (r3 == W3'(FIZZ_MOD - 1));
                  buzz  <= wrap || (r5 == W5'(BUZZ_MOD - 1));
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fizzbuzz_sequencer.sv
// Scoreboard bench for fizzbuzz_sequencer: commands push expected results from
// a plain-arithmetic model; a monitor pops on every accepted handshake.
module tb_fizzbuzz_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, abort, out_ready;
   logic [6:0] first, last, n_out;
   logic       busy, out_valid, fizz, buzz, done;

   typedef struct {
      int n;
      int f;
      int b;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   last_acc = -1;
   int   done_cnt = 0;
   int   rdy_mode = 0;
   int   rdy_ph = 0;
   bit   hold_v = 0;
   int   hold_val = 0;

   fizzbuzz_sequencer #(.BITS(7)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .first     (first),
      .last      (last),
      .abort     (abort),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .n_out     (n_out),
      .fizz      (fizz),
      .buzz      (buzz),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: every n of the wrapped range, classified by plain arithmetic
   task automatic push_range(input int f, input int l);
      int cnt;
      cnt = (((l - f) % 128) + 128) % 128 + 1;
      for (int k = 0; k < cnt; k++) begin
         exp_t e;
         e.n = (f + k) % 128;
         e.f = (e.n % 3 == 0) ? 1 : 0;
         e.b = (e.n % 5 == 0) ? 1 : 0;
         q.push_back(e);
      end
   endtask

   // consumer ready driver: 0 always, 1 random, 2 pattern 1,0,0, 3 stuck low
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin out_ready = (rdy_ph % 3 == 0); rdy_ph++; end
            default: out_ready = 1'b0;
         endcase
      end
   end

   // monitor: compare accepted results, check stalled outputs hold, count done
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_v = 0;
         end else begin
            if (hold_v && out_valid)
               chk("hold", {23'd0, n_out, fizz, buzz}, hold_val);
            hold_v = 0;
            if (out_valid && !abort) begin
               if (out_ready) begin
                  if (q.size() == 0) begin
                     chk("unexpected_result", int'(n_out), -1);
                  end else begin
                     exp_t e;
                     e = q.pop_front();
                     chk("n_out", int'(n_out), e.n);
                     chk("fizz", int'(fizz), e.f);
                     chk("buzz", int'(buzz), e.b);
                  end
                  last_acc = int'(n_out);
               end else begin
                  hold_v   = 1;
                  hold_val = int'({23'd0, n_out, fizz, buzz});
               end
            end
            if (done) done_cnt++;
         end
      end
   end

   // issue a range, wait (bounded) for done, then check done/busy timing
   task automatic run(input int f, input int l, input int mode, input bit ds);
      int c;
      rdy_mode = mode;
      rdy_ph   = 0;
      @(posedge clk); #1;
      start = 1'b1; first = 7'(f); last = 7'(l);
      push_range(f, l);
      @(posedge clk); #1;
      start = 1'b0;
      chk("first_valid", int'(out_valid), 1);
      chk("busy_run", int'(busy), 1);
      c = 0;
      while (!done && c < 2000) begin
         @(negedge clk);
         c++;
      end
      if (!done) begin
         chk("done_timeout", 0, 1);
      end else begin
         chk("queue_empty_at_done", q.size(), 0);
         chk("out_valid_in_done", int'(out_valid), 0);
         if (ds) begin
            start = 1'b1; first = 7'd3; last = 7'd4;
         end
         @(negedge clk);
         start = 1'b0;
         chk("done_one_cycle", int'(done), 0);
         chk("busy_after_done", int'(busy), 0);
      end
      q.delete();
   endtask

   initial begin
      int dc, c;
      reset = 1'b1; start = 1'b0; abort = 1'b0; first = '0; last = '0;
      #12;
      chk("reset_outputs", int'({busy, out_valid, n_out, fizz, buzz, done}), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      run(1, 15, 0, 0);
      run(125, 2, 0, 0);
      run(0, 9, 2, 0);
      run(127, 127, 1, 0);

      // single result, with start ignored while busy and while in DONE
      rdy_mode = 3;
      @(posedge clk); #1;
      start = 1'b1; first = 7'd45; last = 7'd45;
      push_range(45, 45);
      @(posedge clk); #1;
      first = 7'd0; last = 7'd9;     // start still high: must be ignored
      @(posedge clk); #1;
      start = 1'b0;
      chk("n_held_45", int'(n_out), 45);
      rdy_mode = 0;
      c = 0;
      while (!done && c < 50) begin @(negedge clk); c++; end
      chk("done_45", int'(done), 1);
      chk("queue_empty_45", q.size(), 0);
      start = 1'b1; first = 7'd3; last = 7'd4;   // during DONE: ignored
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", int'(busy), 0);
      @(negedge clk);
      chk("still_idle", int'({busy, out_valid}), 0);

      // abort while n_out=7 is presented: that handshake must not count
      dc = done_cnt;
      rdy_mode = 0;
      @(posedge clk); #1;
      start = 1'b1; first = 7'd0; last = 7'd20;
      push_range(0, 20);
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      while (n_out != 7'd7 && c < 50) begin @(posedge clk); #1; c++; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_valid_low", int'(out_valid), 0);
      chk("abort_busy_low", int'(busy), 0);
      chk("abort_last_accepted", last_acc, 6);
      repeat (4) @(negedge clk);
      chk("abort_no_done", done_cnt, dc);
      q.delete();
      run(0, 2, 0, 0);

      // asynchronous reset mid-range while stalled
      dc = done_cnt;
      rdy_mode = 0;
      @(posedge clk); #1;
      start = 1'b1; first = 7'd10; last = 7'd40;
      push_range(10, 40);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      rdy_mode = 3;
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("async_reset_outputs", int'({busy, out_valid, n_out, fizz, buzz, done}), 0);
      q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      rdy_mode = 0;
      repeat (5) @(negedge clk);
      chk("post_reset_idle", int'({busy, out_valid}), 0);
      chk("post_reset_no_done", done_cnt, dc);

      // randomized ranges under random backpressure
      for (int i = 0; i < 8; i++)
         run(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
